gmii_rx_fifo48: RTL and testbench

GMII_RX_FIFO48 -- requirements
Module: gmii_rx_fifo48

---
 rtl/gmii_rx_fifo48_pkg.sv | 16 +
 rtl/gmii_rx_fifo48_packer.sv | 45 ++++
 rtl/gmii_rx_fifo48.sv | 186 ++++++++++++++++++
 tb/tb_gmii_rx_fifo48.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_fifo48_pkg.sv
// Shared types and constants for the GMII receive-to-FIFO packer.
package gmii_rx_fifo48_pkg;

    localparam int         WORD_W        = 48;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

endpackage

// File: rtl/gmii_rx_fifo48_packer.sv
// Big-endian byte-to-48-bit packer: first byte lands in [47:40].
// word_vld is combinational and marks the cycle the sixth byte is presented.
module byte_packer48
    import gmii_rx_fifo48_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_vld
);

    logic [2:0]  lane_q, lane_d;
    logic [39:0] shift_q, shift_d;

    // Lane counter and five-byte shift history; clr holds the packer empty.
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr) begin
            lane_d  = 3'd0;
            shift_d = '0;
        end else if (byte_vld) begin
            shift_d = {shift_q[31:0], byte_in};
            lane_d  = (lane_q == 3'd5) ? 3'd0 : lane_q + 3'd1;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= 3'd0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word     = {shift_q, byte_in};
    assign word_vld = byte_vld && !clr && (lane_q == 3'd5);

endmodule

// File: rtl/gmii_rx_fifo48.sv
// GMII receive framer: strips preamble/SFD and header, packs payload into
// 48-bit FIFO words, and counts accepted and dropped frames.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for rx_dv; first cycle after reset forces DROP
// PREAMBLE   | receiving 0x55 bytes, waiting for SFD
// HEADER     | skipping HDR_BYTES header bytes
// PAYLOAD    | packing bytes, writing a word every sixth byte
// DROP       | ignoring the rest of the frame until rx_dv falls
module gmii_rx_fifo48
    import gmii_rx_fifo48_pkg::*;
#(
    parameter int HDR_BYTES = 14,
    parameter int MAX_WORDS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rxd,
    input  logic              rx_dv,
    input  logic              rx_er,
    input  logic              fifo_full,
    output logic [WORD_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int HCW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int WCW = $clog2(MAX_WORDS + 1);

    state_t            state_q, state_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              rx_dv_q, rx_dv_d;
    logic              rx_er_q, rx_er_d;
    logic [HCW-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic              cap_hit_q, cap_hit_d;
    logic              rst_dly_q;
    logic [WORD_W-1:0] fifo_din_q, fifo_din_d;
    logic              fifo_wr_en_q, fifo_wr_en_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              pack_vld, pack_clr, pack_word_vld;
    logic [WORD_W-1:0] pack_word;

    assign pack_vld = (state_q == ST_PAYLOAD) && rx_dv_q && !rx_er_q;
    assign pack_clr = (state_q != ST_PAYLOAD);

    byte_packer48 u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pack_clr),
        .byte_vld (pack_vld),
        .byte_in  (rxd_q),
        .word     (pack_word),
        .word_vld (pack_word_vld)
    );

    // Next-state, counter and FIFO write decisions from the registered GMII inputs.
    always_comb begin
        rxd_d        = rxd;
        rx_dv_d      = rx_dv;
        rx_er_d      = rx_er;
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        word_cnt_d   = word_cnt_q;
        cap_hit_d    = cap_hit_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                cap_hit_d = 1'b0;
                // A frame cut by reset may still be in flight; wait it out.
                if (rst_dly_q) begin
                    state_d = ST_DROP;
                end else if (rx_dv_q) begin
                    state_d = (rxd_q == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv_q) begin
                    state_d = ST_IDLE;
                end else if (rx_er_q) begin
                    state_d    = ST_DROP;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (rxd_q == SFD_BYTE) begin
                    hdr_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = (HDR_BYTES == 0) ? ST_PAYLOAD : ST_HEADER;
                end else if (rxd_q != PREAMBLE_BYTE) begin
                    state_d = ST_DROP;
                end
            end
            ST_HEADER: begin
                if (!rx_dv_q) begin
                    state_d = ST_IDLE;
                end else if (rx_er_q) begin
                    state_d    = ST_DROP;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (hdr_cnt_q == HCW'(HDR_BYTES - 1)) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + HCW'(1);
                end
            end
            ST_PAYLOAD: begin
                if (!rx_dv_q) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (rx_er_q) begin
                    state_d    = ST_DROP;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (pack_word_vld) begin
                    if (fifo_full) begin
                        state_d    = ST_DROP;
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        fifo_din_d   = pack_word;
                        fifo_wr_en_d = 1'b1;
                        // Word cap reached: frame is good, tail (FCS) is ignored.
                        if (word_cnt_q == WCW'(MAX_WORDS - 1)) begin
                            state_d   = ST_DROP;
                            cap_hit_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!rx_dv_q) begin
                    state_d   = ST_IDLE;
                    cap_hit_d = 1'b0;
                    if (cap_hit_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rxd_q        <= '0;
            rx_dv_q      <= 1'b0;
            rx_er_q      <= 1'b0;
            hdr_cnt_q    <= '0;
            word_cnt_q   <= '0;
            cap_hit_q    <= 1'b0;
            rst_dly_q    <= 1'b1;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rxd_q        <= rxd_d;
            rx_dv_q      <= rx_dv_d;
            rx_er_q      <= rx_er_d;
            hdr_cnt_q    <= hdr_cnt_d;
            word_cnt_q   <= word_cnt_d;
            cap_hit_q    <= cap_hit_d;
            rst_dly_q    <= 1'b0;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fifo_din   = fifo_din_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_rx_fifo48.sv
// Testbench for gmii_rx_fifo48: directed and random frames checked against
// a frame-level reference model (payload chunking, caps, drops).
module tb_gmii_rx_fifo48;

    localparam int HDR = 14;
    localparam int MAXW = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic        fifo_full;
    logic [47:0] fifo_din;
    logic        fifo_wr_en;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        busy;

    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          exp_frames = 0;
    int          exp_drops = 0;

    gmii_rx_fifo48 #(.HDR_BYTES(HDR), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Capture every FIFO write away from the active edge.
    always @(negedge clk) begin
        if (fifo_wr_en) got_q.push_back(fifo_din);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er,
                         input logic full, input logic r);
        @(posedge clk);
        #1;
        rxd       = d;
        rx_dv     = dv;
        rx_er     = er;
        fifo_full = full;
        rst       = r;
    endtask

    // fifo_full is presented in the cycle the DUT processes payload byte idx.
    function automatic logic full_for(input int idx, input int full_word);
        return (full_word >= 0) && (idx >= 0) && ((idx / 6) == full_word);
    endfunction

    task automatic send_frame(input int pre_len, input logic [7:0] sfd, input int hdr_len,
                              input int pay_len, input bit seq_pay, input int err_idx,
                              input int full_word, input int rst_at, input string name);
        logic [7:0]  pay[$];
        logic [47:0] w;
        int          n_avail, nw, nmin;
        bit          acc;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < pay_len; i++)
            pay.push_back(seq_pay ? 8'(i + 1) : 8'($urandom));

        // Reference model: what the frame should produce.
        if (rst_at >= 0) begin
            exp_frames = 0;
            exp_drops  = 0;
        end else if (pre_len > 0 && sfd == 8'hD5 && hdr_len == HDR) begin
            n_avail = (err_idx >= 0) ? err_idx : pay_len;
            nw      = n_avail / 6;
            acc     = (err_idx < 0);
            if (nw >= MAXW) begin
                nw  = MAXW;
                acc = 1'b1;
            end
            if (full_word >= 0 && full_word < nw) begin
                nw  = full_word;
                acc = 1'b0;
            end
            for (int j = 0; j < nw; j++) begin
                w = '0;
                for (int k = 0; k < 6; k++) w = {w[39:0], pay[6*j+k]};
                exp_q.push_back(w);
            end
            if (acc) exp_frames++;
            else     exp_drops++;
        end

        for (int i = 0; i < pre_len; i++) drive(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(sfd, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < hdr_len; i++) drive(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < pay_len; i++) begin
            drive(pay[i], 1'b1, (i == err_idx), full_for(i - 1, full_word),
                  (rst_at >= 0) && (i == rst_at || i == rst_at + 1));
            if (rst_at >= 0 && i == rst_at + 1) begin
                @(negedge clk);
                check({name, " frame_cnt in rst"}, 64'(frame_cnt), 64'd0);
            end
            if (rst_at >= 0 && i == rst_at + 4) begin
                @(negedge clk);
                check({name, " busy after rst"}, 64'(busy), 64'd1);
            end
        end
        drive(8'h00, 1'b0, 1'b0, full_for(pay_len - 1, full_word), 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        check({name, " writes"}, 64'(got_q.size()), 64'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("%s word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({name, " frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_frames)));
        check({name, " drop_cnt"}, 64'(drop_cnt), 64'(16'(exp_drops)));
        check({name, " busy idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int pl, ei, fw;
        rst = 1'b1; rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) drive(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("rst fifo_din", 64'(fifo_din), 64'd0);
        check("rst wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(7, 8'hD5, HDR, 12, 1'b1, -1, -1, -1, "two_words");
        send_frame(7, 8'hD5, HDR, 12, 1'b1, -1, 1, -1, "full_2nd");
        send_frame(7, 8'hD5, HDR, 1500, 1'b0, -1, -1, -1, "max_words");
        send_frame(7, 8'hD5, HDR, 20, 1'b1, 8, -1, -1, "err_byte9");
        send_frame(7, 8'hD5, HDR, 18, 1'b0, -1, -1, -1, "after_err");
        send_frame(7, 8'hD5, HDR, 8, 1'b1, -1, -1, -1, "partial");
        send_frame(7, 8'h12, HDR, 20, 1'b0, -1, -1, -1, "bad_sfd");
        send_frame(0, 8'hD5, HDR, 20, 1'b0, -1, -1, -1, "no_pre");
        send_frame(7, 8'hD5, 5, 0, 1'b0, -1, -1, -1, "short_hdr");
        send_frame(3, 8'hD5, HDR, 0, 1'b0, -1, -1, -1, "empty_pay");

        for (int n = 0; n < 10; n++) begin
            pl = $urandom_range(0, 60);
            ei = (pl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, pl - 1) : -1;
            fw = (pl >= 6 && $urandom_range(0, 3) == 0) ? $urandom_range(0, pl / 6 - 1) : -1;
            send_frame($urandom_range(1, 7), 8'hD5, HDR, pl, 1'b0, ei, fw, -1,
                       $sformatf("rand%0d", n));
        end

        send_frame(7, 8'hD5, HDR, 20, 1'b1, -1, -1, 2, "rst_mid");
        send_frame(7, 8'hD5, HDR, 24, 1'b0, -1, -1, -1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
